// File: rtl/nf10_axis_port_pkt_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO for one output port.
// Whole packets are committed before egress; packets that cannot fit are dropped.
module nf10_axis_port_pkt_fifo #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH            = 512
) (
  input  logic                            aclk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            pkt_dropped,
  output logic [31:0]                     drop_count
);

  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int AW = $clog2(C_DEPTH);
  localparam int MW = 1 + C_AXIS_TUSER_WIDTH + SW + C_AXIS_DATA_WIDTH;
  localparam logic [AW:0] L_FULL = (AW+1)'(C_DEPTH);
  localparam logic [AW:0] L_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    W_IDLE,
    W_PKT,
    W_DROP
  } w_state_t;

  w_state_t    r_state;
  w_state_t    w_state_nxt;

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_commit_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_fe_ptr;
  logic [AW:0] r_pkt_cnt;

  logic [MW-1:0] r_mem [C_DEPTH];
  logic [MW-1:0] r_ent [2];
  logic          r_head;
  logic          r_tail;
  logic [1:0]    r_cnt;

  logic          r_dropped;
  logic [31:0]   r_drop_cnt;

  logic          w_acc;
  logic          w_full;
  logic          w_we;
  logic          w_drop;
  logic          w_commit;
  logic          w_avail;
  logic          w_pop;
  logic          w_pop_last;
  logic          w_fetch;
  logic [MW-1:0] w_wdata;
  logic [MW-1:0] w_out;

  assign s_axis_tready = ~reset;
  assign w_acc    = s_axis_tvalid & s_axis_tready;
  assign w_full   = (r_wr_ptr - r_rd_ptr) == L_FULL;
  assign w_wdata  = {s_axis_tlast, s_axis_tuser,
                     s_axis_tstrb, s_axis_tdata};
  assign w_commit = w_we & s_axis_tlast;

  always_ff @(posedge aclk) begin
    if (reset) r_state <= W_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      W_IDLE, W_PKT: begin
        if (w_acc) begin
          if (s_axis_tlast) w_state_nxt = W_IDLE;
          else if (w_full)  w_state_nxt = W_DROP;
          else              w_state_nxt = W_PKT;
        end
      end
      W_DROP: begin
        if (w_acc && s_axis_tlast)
          w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_we   = 1'b0;
    w_drop = 1'b0;
    if (w_acc && r_state != W_DROP) begin
      w_we   = ~w_full;
      w_drop = w_full;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_we)
      r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
  end

  // A drop rewinds the partial packet back to the last commit point.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_dropped    <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_drop)
        r_wr_ptr <= r_commit_ptr;
      else if (w_we)
        r_wr_ptr <= r_wr_ptr + L_ONE;
      if (w_commit)
        r_commit_ptr <= r_wr_ptr + L_ONE;
      r_dropped <= w_drop;
      if (w_drop && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset)
      r_pkt_cnt <= '0;
    else if (w_commit && !w_pop_last)
      r_pkt_cnt <= r_pkt_cnt + L_ONE;
    else if (!w_commit && w_pop_last)
      r_pkt_cnt <= r_pkt_cnt - L_ONE;
  end

  assign w_avail = (r_fe_ptr != r_commit_ptr) &&
                   (r_pkt_cnt != '0);
  assign m_axis_tvalid = (r_cnt != 2'd0);
  assign w_pop   = m_axis_tvalid & m_axis_tready;
  assign w_fetch = w_avail & ((r_cnt != 2'd2) | w_pop);
  assign w_out   = r_ent[r_head];
  assign {m_axis_tlast, m_axis_tuser,
          m_axis_tstrb, m_axis_tdata} = w_out;
  assign w_pop_last = w_pop & m_axis_tlast;

  // Two-entry prefetch loaded straight from the RAM read port.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_ent[0] <= '0;
      r_ent[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_cnt    <= 2'd0;
      r_fe_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_fetch) begin
        r_ent[r_tail] <= r_mem[r_fe_ptr[AW-1:0]];
        r_tail        <= ~r_tail;
        r_fe_ptr      <= r_fe_ptr + L_ONE;
      end
      if (w_pop) begin
        r_head   <= ~r_head;
        r_rd_ptr <= r_rd_ptr + L_ONE;
      end
      if (w_fetch && !w_pop)
        r_cnt <= r_cnt + 2'd1;
      else if (!w_fetch && w_pop)
        r_cnt <= r_cnt - 2'd1;
    end
  end

  assign pkt_dropped = r_dropped;
  assign drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_nf10_axis_port_pkt_fifo.sv
// Directed bench for the per-port store-and-forward packet FIFO.
// Table-driven first packet, then scoreboarded multi-cycle sequences.
module tb_nf10_axis_port_pkt_fifo;

  localparam int DW    = 256;
  localparam int UW    = 128;
  localparam int SW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [SW-1:0] s_tstrb = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          pkt_dropped;
  logic [31:0]   drop_count;

  always #5 clk = ~clk;

  nf10_axis_port_pkt_fifo #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .C_DEPTH           (DEPTH)
  ) dut (
    .aclk         (clk),
    .reset        (reset),
    .s_axis_tdata (s_tdata),
    .s_axis_tstrb (s_tstrb),
    .s_axis_tuser (s_tuser),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tstrb (m_tstrb),
    .m_axis_tuser (m_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .pkt_dropped  (pkt_dropped),
    .drop_count   (drop_count)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    bit v;
    bit l;
    int k;
    bit r;
    bit ev;
    bit el;
    int ek;
  } vec_t;

  beat_t exp_q[$];
  beat_t mb;
  vec_t  tv[9];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    n_pulse = 0;
  int    p0;
  int    r_len;
  int    r_w;
  bit    mon_en = 1'b0;
  bit    rdone = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [161:0]  prev_c;

  function automatic logic [DW-1:0] pd(int id, int k);
    logic [31:0] w;
    w = {id[15:0], k[15:0]};
    return {8{w}};
  endfunction

  function automatic logic [UW-1:0] pu(int id, int k);
    logic [31:0] w;
    w = {~id[15:0], k[15:0]} ^ 32'h5A5A_0000;
    return {4{w}};
  endfunction

  function automatic logic [SW-1:0] ps(int id, logic last);
    return last ? (32'hFFFF_FFFF >> (id % 32))
                : 32'hFFFF_FFFF;
  endfunction

  function automatic beat_t mk(int id, int k, int len);
    beat_t b;
    b.l = (k == len - 1);
    b.d = pd(id, k);
    b.u = pu(id, k);
    b.s = ps(id, b.l);
    return b;
  endfunction

  task automatic chk(string nm, logic [255:0] act,
                     logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(beat_t b);
    s_tdata  = b.d;
    s_tstrb  = b.s;
    s_tuser  = b.u;
    s_tlast  = b.l;
    s_tvalid = 1'b1;
  endtask

  task automatic idle_in();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_pkt(int id, int len, bit push);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b = mk(id, k, len);
      drive(b);
      if (push) exp_q.push_back(b);
      tick();
    end
    idle_in();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    idle_in();
    reset = 1'b1;
    tick();
    chk("tready_in_reset", 256'(s_tready), 256'(0));
    tick();
    chk("rst_tvalid", 256'(m_tvalid), 256'(0));
    chk("rst_tlast", 256'(m_tlast), 256'(0));
    chk("rst_tdata", 256'(m_tdata), 256'(0));
    chk("rst_side", 256'({m_tstrb, m_tuser}), 256'(0));
    chk("rst_drop", 256'({pkt_dropped, drop_count}), 256'(0));
    reset = 1'b0;
    exp_q.delete();
    tick();
    chk("tready_after_reset", 256'(s_tready), 256'(1));
  endtask

  task automatic wait_drain(string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk(nm, 256'(exp_q.size()), 256'(0));
    repeat (4) tick();
  endtask

  always @(negedge clk) begin
    if (pkt_dropped) n_pulse++;
    if (mon_en && !reset) begin
      if (prev_stall) begin
        chk("stall_data", m_tdata, prev_d);
        chk("stall_ctrl",
            256'({m_tvalid, m_tlast, m_tstrb, m_tuser}),
            256'(prev_c));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h want none",
                   m_tdata);
        end else begin
          mb = exp_q.pop_front();
          chk("egress_data", m_tdata, mb.d);
          chk("egress_ctrl",
              256'({m_tlast, m_tstrb, m_tuser}),
              256'({mb.l, mb.s, mb.u}));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_c = {m_tvalid, m_tlast, m_tstrb, m_tuser};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1, 0, 0, 1, 0, 0, 0};
    tv[1] = '{1, 0, 1, 1, 0, 0, 0};
    tv[2] = '{1, 0, 2, 1, 0, 0, 0};
    tv[3] = '{1, 1, 3, 1, 0, 0, 0};
    tv[4] = '{0, 0, 0, 1, 1, 0, 0};
    tv[5] = '{0, 0, 0, 1, 1, 0, 1};
    tv[6] = '{0, 0, 0, 1, 1, 0, 2};
    tv[7] = '{0, 0, 0, 1, 1, 1, 3};
    tv[8] = '{0, 0, 0, 1, 0, 0, 0};

    // T1: single 4-beat packet, 2-cycle latency after tlast
    do_reset();
    for (int i = 0; i < 9; i++) begin
      s_tvalid = tv[i].v;
      s_tlast  = tv[i].l;
      s_tdata  = pd(16, tv[i].k);
      s_tuser  = pu(16, tv[i].k);
      s_tstrb  = ps(16, tv[i].l);
      m_tready = tv[i].r;
      tick();
      chk($sformatf("t1_vld[%0d]", i),
          256'(m_tvalid), 256'(tv[i].ev));
      chk($sformatf("t1_lst[%0d]", i),
          256'(m_tlast), 256'(tv[i].el));
      if (tv[i].ev) begin
        chk($sformatf("t1_data[%0d]", i),
            m_tdata, pd(16, tv[i].ek));
        chk($sformatf("t1_user[%0d]", i),
            256'(m_tuser), 256'(pu(16, tv[i].ek)));
        chk($sformatf("t1_strb[%0d]", i),
            256'(m_tstrb), 256'(ps(16, tv[i].el)));
      end
    end
    idle_in();
    chk("t1_drop_count", 256'(drop_count), 256'(0));

    // T2: stalled egress, second packet overflows and is dropped
    do_reset();
    m_tready = 1'b0;
    mon_en = 1'b1;
    p0 = n_pulse;
    send_pkt(100, 10, 1);
    send_pkt(200, 8, 0);
    repeat (3) tick();
    chk("t2_pulses", 256'(n_pulse - p0), 256'(1));
    chk("t2_drop_count", 256'(drop_count), 256'(1));
    chk("t2_held_vld", 256'(m_tvalid), 256'(1));
    chk("t2_held_data", m_tdata, pd(100, 0));
    m_tready = 1'b1;
    wait_drain("t2_drain");

    // T3: oversized packet dropped, following packet intact
    do_reset();
    m_tready = 1'b1;
    mon_en = 1'b1;
    p0 = n_pulse;
    send_pkt(300, 17, 0);
    chk("t3_pulse_hi", 256'(pkt_dropped), 256'(1));
    chk("t3_drop_count", 256'(drop_count), 256'(1));
    chk("t3_wr_rewind", 256'(dut.r_wr_ptr), 256'(0));
    tick();
    chk("t3_pulse_lo", 256'(pkt_dropped), 256'(0));
    send_pkt(301, 2, 1);
    wait_drain("t3_drain");
    chk("t3_pulses", 256'(n_pulse - p0), 256'(1));

    // T5: reset mid-packet while another packet egresses
    mon_en = 1'b0;
    m_tready = 1'b1;
    send_pkt(500, 5, 0);
    for (int k = 0; k < 2; k++) begin
      drive(mk(600, k, 6));
      tick();
    end
    chk("t5_egressing", 256'(m_tvalid), 256'(1));
    drive(mk(600, 2, 6));
    reset = 1'b1;
    tick();
    chk("t5_rst_vld", 256'({m_tvalid, m_tlast}), 256'(0));
    chk("t5_rst_data", m_tdata, 256'(0));
    chk("t5_rst_side", 256'({m_tstrb, m_tuser}), 256'(0));
    chk("t5_rst_drop",
        256'({pkt_dropped, drop_count}), 256'(0));
    idle_in();
    reset = 1'b0;
    exp_q.delete();
    tick();
    mon_en = 1'b1;
    send_pkt(700, 3, 1);
    wait_drain("t5_drain");

    // T4: 100 random packets, random egress backpressure
    do_reset();
    mon_en = 1'b1;
    p0 = n_pulse;
    rdone = 1'b0;
    fork
      begin
        for (int p = 0; p < 100; p++) begin
          r_len = $urandom_range(1, 8);
          r_w = 0;
          while (exp_q.size() + r_len > DEPTH && r_w < 1000) begin
            tick();
            r_w++;
          end
          if (r_w >= 1000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL t4_space_wait: got %0d want <1000", r_w);
          end
          send_pkt(1000 + p, r_len, 1);
          if ($urandom_range(0, 3) == 0) tick();
        end
        wait_drain("t4_drain");
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          m_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    chk("t4_no_drops", 256'(n_pulse - p0), 256'(0));
    chk("t4_drop_count", 256'(drop_count), 256'(0));

    // T6: drop counter saturation
    m_tready = 1'b1;
    force dut.r_drop_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.r_drop_cnt;
    tick();
    chk("t6_preset", 256'(drop_count), 256'(32'hFFFF_FFFE));
    p0 = n_pulse;
    send_pkt(800, 17, 0);
    chk("t6_first", 256'(drop_count), 256'(32'hFFFF_FFFF));
    send_pkt(801, 17, 0);
    send_pkt(802, 17, 0);
    tick();
    chk("t6_sat", 256'(drop_count), 256'(32'hFFFF_FFFF));
    chk("t6_pulses", 256'(n_pulse - p0), 256'(3));
    repeat (3) tick();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
